riscv_fetch_queue: RTL

//  Instruction fetch front end feeding the core's decode stage from the 4-wide instruction memory port.

---
 rtl/riscv_fetch_pkg.sv | 30 +++
 rtl/riscv_fetch_qram.sv | 52 +++++
 rtl/riscv_fetch_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

  // Words delivered by the instruction memory per fetch.
  localparam int BUNDLE_W = 4;

  // Word address fetched first after reset (byte address 0x0040_0000).
  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0010_0000;

  // One queue slot: instruction word, its word address, fault marker.
  typedef struct packed {
    logic [31:0] inst;
    logic [29:0] pc;
    logic        excpt;
  } fq_entry_t;

  // Fetch control state.
  typedef enum logic [1:0] {
    FQ_FETCH  = 2'd0,
    FQ_EXCPT  = 2'd1,
    FQ_HALTED = 2'd2
  } fq_state_t;

endpackage : riscv_fetch_pkg
`default_nettype wire

// File: rtl/riscv_fetch_qram.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_qram
// Description : DEPTH-entry register array for the fetch queue. One write
//               port updating up to BUNDLE_W consecutive slots starting at a
//               base index (wrapping mod DEPTH) and one asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_qram
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           wr_en,
  input  logic [BUNDLE_W-1:0]            wr_mask,
  input  logic [AW-1:0]                  wr_base,
  input  fq_entry_t [BUNDLE_W-1:0]       wr_data,
  input  logic [AW-1:0]                  rd_idx,
  output fq_entry_t                      rd_data
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  // Next array contents: lane k lands at slot wr_base+k, wrapping naturally.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int k = 0; k < BUNDLE_W; k++) begin
        if (wr_mask[k]) begin
          mem_d[wr_base + AW'(k)] = wr_data[k];
        end
      end
    end
  end

  // Storage; cleared on reset so the head reads as all zeros.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule : riscv_fetch_qram
`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_queue
// Description : Instruction fetch front end. Presents a word address to the
//               4-wide instruction memory, queues the returned words in a
//               circular buffer and hands them to decode one per cycle.
//               Handles redirects, fetch faults and halt.
//               Optional feature macro: FETCH_PERF_EN (adds perf_bundles and
//               perf_stall counter outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_b,
  output logic [29:0]               inst_addr,
  input  logic [BUNDLE_W-1:0][31:0] inst,
  input  logic                      inst_excpt,
  output logic                      dec_valid,
  output logic [31:0]               dec_inst,
  output logic [29:0]               dec_pc,
  output logic                      dec_excpt,
  input  logic                      dec_ready,
  input  logic                      redirect_valid,
  input  logic [29:0]               redirect_pc,
  input  logic                      halt_req
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_bundles,
  output logic [31:0]               perf_stall
`endif
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - BUNDLE_W);

  fq_state_t     state_q, state_d;
  logic [29:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic                     halt_go;
  logic                     redir;
  logic                     enq;
  logic                     enq_full;
  logic                     enq_fault;
  logic                     deq;
  logic [CW-1:0]            enq_n;
  logic [BUNDLE_W-1:0]      wr_mask;
  fq_entry_t [BUNDLE_W-1:0] wr_data;
  fq_entry_t                head;

  // Handshake and enqueue decisions; enqueue looks only at registered count.
  always_comb begin
    halt_go   = halt_req && (state_q != FQ_HALTED);
    redir     = redirect_valid && (state_q != FQ_HALTED);
    enq       = (state_q == FQ_FETCH) && !redirect_valid && !halt_req &&
                (count_q <= ENQ_LIMIT);
    enq_full  = enq && !inst_excpt;
    enq_fault = enq && inst_excpt;
    deq       = dec_valid && dec_ready && !redir;
    enq_n     = enq_full ? CW'(BUNDLE_W) : (enq_fault ? CW'(1) : '0);
  end

  // Write lanes: full bundle, or a single fault marker in lane 0.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int k = 0; k < BUNDLE_W; k++) begin
      if (enq_fault) begin
        wr_data[k] = '{inst: 32'h0, pc: pc_q, excpt: 1'b1};
      end else begin
        wr_data[k] = '{inst: inst[k], pc: pc_q + 30'(k), excpt: 1'b0};
      end
    end
    if (enq_full) begin
      wr_mask = '1;
    end else if (enq_fault) begin
      wr_mask = BUNDLE_W'(1);
    end
  end

  riscv_fetch_qram #(
    .DEPTH (DEPTH)
  ) u_qram (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (enq),
    .wr_mask (wr_mask),
    .wr_base (wr_q),
    .wr_data (wr_data),
    .rd_idx  (rd_q),
    .rd_data (head)
  );

  // Next pointers, count, pc and state; a flush overrides normal movement.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redir) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      pc_d    = halt_go ? pc_q : redirect_pc;
      state_d = halt_go ? FQ_HALTED : FQ_FETCH;
    end else begin
      rd_d    = rd_q + AW'(deq);
      wr_d    = wr_q + AW'(enq_n);
      count_d = count_q + enq_n - CW'(deq);
      if (enq_full) begin
        pc_d = pc_q + 30'(BUNDLE_W);
      end
      if (halt_go) begin
        state_d = FQ_HALTED;
      end else if (enq_fault) begin
        state_d = FQ_EXCPT;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= FQ_FETCH;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign inst_addr = pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_inst  = head.inst;
  assign dec_pc    = head.pc;
  assign dec_excpt = head.excpt && dec_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bundles_q, perf_bundles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count full-bundle enqueues and cycles lost to a full queue.
  always_comb begin
    perf_bundles_d = perf_bundles_q + 32'(enq_full);
    perf_stall_d   = perf_stall_q +
                     32'((state_q == FQ_FETCH) && !redirect_valid &&
                         (count_q > ENQ_LIMIT));
  end

  // Counter registers; wrap naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_bundles_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_bundles = perf_bundles_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule : riscv_fetch_queue
`default_nettype wire
